fft32_out_serializer: RTL and testbench

Downstream neighbour of the 32-point DIF FFT stage. It captures one complete 32-point parallel complex result frame (natural-order R0..R31 / I0..I31, 37-bit signed) in a single cycle. It then streams the frame out one complex sample per beat, in index order 0..31, over a valid/ready interface. Two frame banks (ping-pong) let the next FFT frame be accepted while the current one drains.

---
 rtl/fft32_pkg.sv | 15 +
 rtl/fft_frame_bank.sv | 44 ++++
 rtl/fft32_out_serializer.sv | 109 ++++++++++
 tb/tb_fft32_out_serializer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fft32_pkg.sv
// Shared constants and sample/frame types for the FFT output serializer.
package fft32_pkg;

   localparam int N     = 32;
   localparam int DW    = 37;
   localparam int IDX_W = $clog2(N);

   typedef struct packed {
      logic signed [DW-1:0] re;
      logic signed [DW-1:0] im;
   } sample_t;

   typedef sample_t frame_t [N];

endpackage

// File: rtl/fft_frame_bank.sv
// One frame buffer: N complex samples captured in a single cycle, a full
// flag set on load and cleared on the final beat, and a read-index mux.
module fft_frame_bank
   import fft32_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_load,
   input  logic              i_clear,
   input  logic [N*DW-1:0]   i_re,
   input  logic [N*DW-1:0]   i_im,
   input  logic [IDX_W-1:0]  i_idx,
   output logic              o_full,
   output sample_t           o_sample
);

   frame_t r_frame;
   logic   r_full;

   // Capture the whole flattened frame; sample data deliberately has no reset.
   always_ff @(posedge clk) begin
      if (i_load) begin
         for (int k = 0; k < N; k++) begin
            r_frame[k].re <= i_re[k*DW +: DW];
            r_frame[k].im <= i_im[k*DW +: DW];
         end
      end
   end

   // Occupancy flag; load wins, though the controller never asserts both.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_full <= 1'b0;
      end else if (i_load) begin
         r_full <= 1'b1;
      end else if (i_clear) begin
         r_full <= 1'b0;
      end
   end

   assign o_full   = r_full;
   assign o_sample = r_frame[i_idx];

endmodule

// File: rtl/fft32_out_serializer.sv
// Ping-pong serializer: accepts a full parallel FFT frame into a free bank
// and streams it out one complex sample per valid/ready beat, index order.
module fft32_out_serializer
   import fft32_pkg::*;
#(
   parameter  int SHIFT = 0,
   localparam int OW    = DW - SHIFT
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [N*DW-1:0]       in_re,
   input  logic [N*DW-1:0]       in_im,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic signed [OW-1:0]  out_re,
   output logic signed [OW-1:0]  out_im,
   output logic [IDX_W-1:0]      out_idx,
   output logic                  out_last
);

   logic             r_wr_sel;
   logic             r_rd_sel;
   logic [IDX_W-1:0] r_rd_idx;

   logic [1:0]       w_full;
   logic [1:0]       w_load;
   logic [1:0]       w_clear;
   sample_t          w_rd [2];
   sample_t          w_cur;
   logic             w_accept;
   logic             w_beat;
   logic             w_end;
   logic             w_at_last;

   assign in_ready  = !w_full[r_wr_sel];
   assign out_valid = w_full[r_rd_sel];
   assign w_accept  = in_valid && in_ready;
   assign w_at_last = (r_rd_idx == IDX_W'(N-1));
   assign w_beat    = out_valid && out_ready;
   assign w_end     = w_beat && w_at_last;

   assign w_load[0]  = w_accept && !r_wr_sel;
   assign w_load[1]  = w_accept &&  r_wr_sel;
   assign w_clear[0] = w_end && !r_rd_sel;
   assign w_clear[1] = w_end &&  r_rd_sel;

   fft_frame_bank u_bank0 (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_load   (w_load[0]),
      .i_clear  (w_clear[0]),
      .i_re     (in_re),
      .i_im     (in_im),
      .i_idx    (r_rd_idx),
      .o_full   (w_full[0]),
      .o_sample (w_rd[0])
   );

   fft_frame_bank u_bank1 (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_load   (w_load[1]),
      .i_clear  (w_clear[1]),
      .i_re     (in_re),
      .i_im     (in_im),
      .i_idx    (r_rd_idx),
      .o_full   (w_full[1]),
      .o_sample (w_rd[1])
   );

   // Output view of the draining bank, forced to zero whenever nothing is valid.
   always_comb begin
      w_cur    = w_rd[r_rd_sel];
      out_re   = '0;
      out_im   = '0;
      out_idx  = '0;
      out_last = 1'b0;
      if (out_valid) begin
         out_re   = OW'($signed(w_cur.re) >>> SHIFT);
         out_im   = OW'($signed(w_cur.im) >>> SHIFT);
         out_idx  = r_rd_idx;
         out_last = w_at_last;
      end
   end

   // Bank selection and read pointer; a load and a final beat may coincide.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_sel <= 1'b0;
         r_rd_sel <= 1'b0;
         r_rd_idx <= '0;
      end else begin
         if (w_accept) begin
            r_wr_sel <= !r_wr_sel;
         end
         if (w_beat) begin
            if (w_at_last) begin
               r_rd_idx <= '0;
               r_rd_sel <= !r_rd_sel;
            end else begin
               r_rd_idx <= r_rd_idx + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_fft32_out_serializer.sv
// Directed bench for fft32_out_serializer: a SHIFT=0 instance and a SHIFT=4
// instance share all stimulus so their control paths stay in lock step.
module tb_fft32_out_serializer;
   import fft32_pkg::*;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 in_valid;
   logic                 out_ready;
   logic [N*DW-1:0]      in_re;
   logic [N*DW-1:0]      in_im;

   logic                 in_ready0, out_valid0, out_last0;
   logic signed [DW-1:0] out_re0, out_im0;
   logic [IDX_W-1:0]     out_idx0;

   logic                 in_ready4, out_valid4, out_last4;
   logic signed [32:0]   out_re4, out_im4;
   logic [IDX_W-1:0]     out_idx4;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      longint re;
      longint im;
      longint e_re0;
      longint e_im0;
      longint e_re4;
      longint e_im4;
   } ext_vec_t;

   ext_vec_t ext_tab [5];

   always #5 clk = ~clk;

   fft32_out_serializer #(.SHIFT(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
      .in_re(in_re), .in_im(in_im), .out_valid(out_valid0), .out_ready(out_ready),
      .out_re(out_re0), .out_im(out_im0), .out_idx(out_idx0), .out_last(out_last0)
   );

   fft32_out_serializer #(.SHIFT(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
      .in_re(in_re), .in_im(in_im), .out_valid(out_valid4), .out_ready(out_ready),
      .out_re(out_re4), .out_im(out_im4), .out_idx(out_idx4), .out_last(out_last4)
   );

   task automatic chk(input string nm, input logic signed [63:0] act,
                      input logic signed [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_frame(input longint re0, input longint re_step,
                            input longint im0, input longint im_step);
      for (int k = 0; k < N; k++) begin
         in_re[k*DW +: DW] = DW'(re0 + re_step * longint'(k));
         in_im[k*DW +: DW] = DW'(im0 + im_step * longint'(k));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int     acc;
      int     beats;
      int     f_off;
      int     c31;
      int     cf2;
      int     fr;
      int     ix;
      logic   started;
      logic   found;
      longint p36;
      longint p32;

      p36 = longint'(1) << 36;
      p32 = longint'(1) << 32;
      ext_tab[0] = '{p36 - 1, -p36,     p36 - 1, -p36,     p32 - 1, -p32};
      ext_tab[1] = '{-1,      -1,       -1,      -1,       -1,      -1};
      ext_tab[2] = '{17,      -17,      17,      -17,      1,       -2};
      ext_tab[3] = '{0,       5,        0,       5,        0,       0};
      ext_tab[4] = '{-p36,    p36 - 1,  -p36,    p36 - 1,  -p32,    p32 - 1};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_re     = '0;
      in_im     = '0;
      #12;
      chk("rst_in_ready",  in_ready0,  1);
      chk("rst_out_valid", out_valid0, 0);
      chk("rst_out_idx",   out_idx0,   0);
      chk("rst_out_re",    out_re0,    0);
      chk("rst_out_im",    out_im0,    0);
      chk("rst_out_last",  out_last0,  0);
      rst_n = 1'b1;
      tick();

      // single frame, continuous drain
      set_frame(0, 1, 0, -1);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < N; k++) begin
         chk("sf_valid", out_valid0, 1);
         chk("sf_idx",   out_idx0,   k);
         chk("sf_re",    out_re0,    k);
         chk("sf_im",    out_im0,    -k);
         chk("sf_last",  out_last0,  (k == N-1));
         tick();
      end
      chk("sf_empty", out_valid0, 0);

      // back-pressure with a 1,0,0,1 ready pattern
      set_frame(0, 1, 0, -1);
      in_valid  = 1'b1;
      out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      acc = 0;
      for (int c = 0; c < 200 && acc < N; c++) begin
         out_ready = ((c % 4) == 0) || ((c % 4) == 3);
         chk("bp_valid", out_valid0, 1);
         chk("bp_idx",   out_idx0,   acc);
         chk("bp_re",    out_re0,    acc);
         chk("bp_im",    out_im0,    -acc);
         chk("bp_last",  out_last0,  (acc == N-1));
         if (out_ready) acc++;
         tick();
      end
      chk("bp_count", acc, N);
      chk("bp_empty", out_valid0, 0);

      // ping-pong: three frames offered back to back, continuous drain
      out_ready = 1'b1;
      beats   = 0;
      f_off   = 0;
      c31     = -1;
      cf2     = -1;
      started = 1'b0;
      for (int c = 0; c < 300 && beats < 3*N; c++) begin
         if (f_off < 3) begin
            set_frame(100*(f_off+1), 1, -100*(f_off+1), -1);
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         if (out_valid0) begin
            started = 1'b1;
            fr = beats / N;
            ix = beats % N;
            chk("pp_idx",  out_idx0,  ix);
            chk("pp_re",   out_re0,   100*(fr+1) + ix);
            chk("pp_im",   out_im0,   -(100*(fr+1) + ix));
            chk("pp_last", out_last0, (ix == N-1));
            if (beats == N-1) c31 = c;
            beats++;
         end else if (started) begin
            chk("pp_gap", out_valid0, 1);
         end
         if (in_valid && in_ready0) begin
            if (f_off == 2) cf2 = c;
            f_off++;
         end
         tick();
      end
      in_valid = 1'b0;
      chk("pp_beats",    beats, 3*N);
      chk("pp_accepted", f_off, 3);
      chk("pp_f2_cycle", cf2,   c31 + 1);
      chk("pp_empty",    out_valid0, 0);

      // reset in the middle of a frame with a second frame pending
      out_ready = 1'b1;
      set_frame(100, 1, -100, -1);
      in_valid = 1'b1;
      tick();
      set_frame(200, 1, -200, -1);
      tick();
      in_valid = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 40 && !found; c++) begin
         if (out_valid0 && out_idx0 == 5'd10) found = 1'b1;
         else tick();
      end
      chk("mr_reached_10", found, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mr_valid",    out_valid0, 0);
      chk("mr_in_ready", in_ready0,  1);
      chk("mr_idx",      out_idx0,   0);
      chk("mr_re",       out_re0,    0);
      chk("mr_im",       out_im0,    0);
      chk("mr_last",     out_last0,  0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("mr_idle", out_valid0, 0);
      set_frame(500, 3, -7, 2);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < N; k++) begin
         chk("mr_valid_new", out_valid0, 1);
         chk("mr_idx_new",   out_idx0,   k);
         chk("mr_re_new",    out_re0,    500 + 3*k);
         chk("mr_im_new",    out_im0,    -7 + 2*k);
         tick();
      end
      chk("mr_no_stale", out_valid0, 0);

      // extreme values through both shift settings
      for (int v = 0; v < 5; v++) begin
         set_frame(ext_tab[v].re, 0, ext_tab[v].im, 0);
         in_valid  = 1'b1;
         out_ready = 1'b0;
         tick();
         in_valid = 1'b0;
         chk($sformatf("ext%0d_valid0", v),   out_valid0, 1);
         chk($sformatf("ext%0d_valid4", v),   out_valid4, 1);
         chk($sformatf("ext%0d_idx4", v),     out_idx4,   0);
         chk($sformatf("ext%0d_rdy4", v),     in_ready4,  1);
         chk($sformatf("ext%0d_last4", v),    out_last4,  0);
         chk($sformatf("ext%0d_re_s0", v),    out_re0,    ext_tab[v].e_re0);
         chk($sformatf("ext%0d_im_s0", v),    out_im0,    ext_tab[v].e_im0);
         chk($sformatf("ext%0d_re_s4", v),    out_re4,    ext_tab[v].e_re4);
         chk($sformatf("ext%0d_im_s4", v),    out_im4,    ext_tab[v].e_im4);
         out_ready = 1'b1;
         for (int c = 0; c < 40 && out_valid0; c++) tick();
         chk($sformatf("ext%0d_drained", v), out_valid0, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
